// File: rtl/sfm_lane_dispatcher.sv
// sfm_lane_dispatcher: round-robin fan-out of a stream onto N lanes
// with in-order collection of the lane results back into one stream.
module sfm_lane_dispatcher #(
    parameter int DATA_WIDTH = 288,
    parameter int ELEM_WIDTH = 16,
    parameter int N_LANES    = 2,
    parameter int MAX_OUT    = 4,
    localparam int ADW = DATA_WIDTH - 32,
    localparam int VW  = ADW / ELEM_WIDTH,
    localparam int SW  = DATA_WIDTH / 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          enable_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [DATA_WIDTH-1:0]         in_data_i,
    input  logic [SW-1:0]                 in_strb_i,
    output logic [N_LANES-1:0]            lane_valid_o,
    input  logic [N_LANES-1:0]            lane_ready_i,
    output logic [ADW-1:0]                lane_data_o,
    output logic [VW-1:0]                 lane_strb_o,
    input  logic [N_LANES-1:0]            res_valid_i,
    output logic [N_LANES-1:0]            res_ready_o,
    input  logic [N_LANES-1:0][ADW-1:0]   res_data_i,
    input  logic [N_LANES-1:0][VW-1:0]    res_strb_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DATA_WIDTH-1:0]         out_data_o,
    output logic [SW-1:0]                 out_strb_o,
    output logic                          busy_o,
    output logic                          err_o
);

    localparam int E  = ELEM_WIDTH / 8;
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int PW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);

    logic [PW-1:0] dp_q, dp_d;
    logic [PW-1:0] cp_q, cp_d;
    logic [CW-1:0] cnt_q [N_LANES];
    logic [CW-1:0] cnt_d [N_LANES];
    logic          err_q, err_d;

    logic dp_ok, cp_ok;
    logic in_hs, out_hs;
    logic err_set;
    logic unused_bits;

    // Reserved top word and its strobes carry nothing into the lanes.
    assign unused_bits = ^{in_data_i[DATA_WIDTH-1:ADW], in_strb_i[SW-1:VW*E]};

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == PW'(N_LANES - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign dp_ok = enable_i && (cnt_q[dp_q] < MAX_C);
    assign cp_ok = (cnt_q[cp_q] != '0);

    assign in_ready_o  = lane_ready_i[dp_q] && dp_ok;
    assign out_valid_o = res_valid_i[cp_q] && cp_ok;
    assign in_hs       = in_valid_i && in_ready_o;
    assign out_hs      = out_valid_o && out_ready_i;

    assign lane_data_o = in_data_i[ADW-1:0];
    assign out_data_o  = {32'h0, res_data_i[cp_q]};
    assign err_o       = err_q;

    // Only the lane under each pointer sees a handshake.
    always_comb begin
        lane_valid_o       = '0;
        res_ready_o        = '0;
        lane_valid_o[dp_q] = in_valid_i && dp_ok;
        res_ready_o[cp_q]  = out_ready_i && cp_ok;
    end

    // An element is valid only if all its bytes are strobed.
    always_comb begin
        lane_strb_o = '0;
        for (int i = 0; i < VW; i++) begin
            lane_strb_o[i] = &in_strb_i[i*E +: E];
        end
    end

    // Fan element strobes of the collected result back out to bytes.
    always_comb begin
        out_strb_o = '0;
        for (int i = 0; i < VW; i++) begin
            out_strb_o[i*E +: E] = {E{res_strb_i[cp_q][i]}};
        end
    end

    // Occupancy summary and unexpected-result detection.
    always_comb begin
        busy_o  = 1'b0;
        err_set = 1'b0;
        for (int k = 0; k < N_LANES; k++) begin
            if (cnt_q[k] != '0) begin
                busy_o = 1'b1;
            end else if (res_valid_i[k]) begin
                err_set = 1'b1;
            end
        end
    end

    // Next-state for pointers, in-flight counters and error flag.
    always_comb begin
        dp_d  = in_hs ? ptr_next(dp_q) : dp_q;
        cp_d  = out_hs ? ptr_next(cp_q) : cp_q;
        err_d = err_q | err_set;
        for (int k = 0; k < N_LANES; k++) begin
            cnt_d[k] = cnt_q[k];
            if ((in_hs && dp_q == PW'(k)) && !(out_hs && cp_q == PW'(k))) begin
                cnt_d[k] = cnt_q[k] + CW'(1);
            end else if (!(in_hs && dp_q == PW'(k)) && (out_hs && cp_q == PW'(k))) begin
                cnt_d[k] = cnt_q[k] - CW'(1);
            end
        end
    end

    // State registers; clear wins over any same-cycle handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dp_q  <= '0;
            cp_q  <= '0;
            err_q <= 1'b0;
            for (int k = 0; k < N_LANES; k++) begin
                cnt_q[k] <= '0;
            end
        end else if (clear_i) begin
            dp_q  <= '0;
            cp_q  <= '0;
            err_q <= 1'b0;
            for (int k = 0; k < N_LANES; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            dp_q  <= dp_d;
            cp_q  <= cp_d;
            err_q <= err_d;
            for (int k = 0; k < N_LANES; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

endmodule

// File: tb/tb_sfm_lane_dispatcher.sv
// tb_sfm_lane_dispatcher: strobe vector table, directed ordering and
// corner sequences, and a random run against a queue-based model.
module tb_sfm_lane_dispatcher;

    localparam int DW  = 288;
    localparam int EW  = 16;
    localparam int N   = 2;
    localparam int MO  = 4;
    localparam int ADW = DW - 32;
    localparam int VW  = ADW / EW;
    localparam int SW  = DW / 8;
    localparam int E   = EW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_n = 1'b0;
    logic                    clear, enable;
    logic                    in_valid, in_ready;
    logic [DW-1:0]           in_data;
    logic [SW-1:0]           in_strb;
    logic [N-1:0]            lane_valid, lane_ready;
    logic [ADW-1:0]          lane_data;
    logic [VW-1:0]           lane_strb;
    logic [N-1:0]            res_valid, res_ready;
    logic [N-1:0][ADW-1:0]   res_data;
    logic [N-1:0][VW-1:0]    res_strb;
    logic                    out_valid, out_ready;
    logic [DW-1:0]           out_data;
    logic [SW-1:0]           out_strb;
    logic                    busy, err;

    sfm_lane_dispatcher #(
        .DATA_WIDTH(DW), .ELEM_WIDTH(EW), .N_LANES(N), .MAX_OUT(MO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .in_strb_i(in_strb),
        .lane_valid_o(lane_valid), .lane_ready_i(lane_ready),
        .lane_data_o(lane_data), .lane_strb_o(lane_strb),
        .res_valid_i(res_valid), .res_ready_o(res_ready),
        .res_data_i(res_data), .res_strb_i(res_strb),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_strb_o(out_strb),
        .busy_o(busy), .err_o(err)
    );

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        logic [SW-1:0] istrb;
        logic [VW-1:0] rstrb;
        logic [VW-1:0] exp_ls;
        logic [SW-1:0] exp_os;
    } vec_t;
    vec_t vt[4];

    // model state: dispatch order queue, per-lane result fifos
    bit [ADW-1:0] qexp[$];
    bit [ADW-1:0] lq[N][$];
    int nin, nout;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        clear = 0; enable = 0; in_valid = 0; lane_ready = '0;
        res_valid = '0; out_ready = 0; in_data = '0; in_strb = '0;
        res_data = '0; res_strb = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 0;
        #1;
        res_valid = '1;
        out_ready = 1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_res_ready", res_ready, 0);
        chk("rst_err", err, 0);
        res_valid = '0;
        out_ready = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    // beats of lane k currently in flight, from the dispatch order
    function automatic int mcnt(input int k);
        int c = 0;
        for (int j = nout; j < nin; j++) begin
            if (j % N == k) c++;
        end
        return c;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dpl, cpl, got;
        logic exp_ir, exp_ov;
        logic [N-1:0] exp_lv, exp_rr;
        logic [VW-1:0] exp_ls;
        logic [SW-1:0] exp_os;

        vt[0] = '{36'h0_0000_FFF3, 16'h0001, 16'h00FD, 36'h0_0000_0003};
        vt[1] = '{36'hF_FFFF_FFFF, 16'hFFFF, 16'hFFFF, 36'h0_FFFF_FFFF};
        vt[2] = '{36'hA_AAAA_AAAA, 16'h8001, 16'h0000, 36'h0_C000_0003};
        vt[3] = '{36'hF_0000_3C0F, 16'h0110, 16'h0063, 36'h0_0003_0300};

        idle();
        do_reset();

        // strobe mapping table (cp = 0 after reset)
        for (int i = 0; i < 4; i++) begin
            in_strb = vt[i].istrb;
            res_strb[0] = vt[i].rstrb;
            #1;
            chk($sformatf("tbl%0d_lane_strb", i), lane_strb, vt[i].exp_ls);
            chk($sformatf("tbl%0d_out_strb", i), out_strb, vt[i].exp_os);
            @(negedge clk);
        end

        // ordering: lane 1 answers first but is held until lane 0
        do_reset();
        enable = 1; lane_ready = '1; out_ready = 1; in_valid = 1;
        for (int i = 1; i <= 4; i++) begin
            in_data = DW'(i);
            #1;
            chk("A_in_ready", in_ready, 1);
            chk("A_lane_valid", lane_valid, (i % 2 == 1) ? 2'b01 : 2'b10);
            chk("A_lane_data", lane_data, ADW'(i));
            @(negedge clk);
        end
        in_valid = 0; res_valid = 2'b10; res_data[1] = ADW'(2);
        #1;
        chk("A_held_out_valid", out_valid, 0);
        chk("A_held_res_ready1", res_ready[1], 0);
        @(negedge clk);
        res_valid = 2'b11; res_data[0] = ADW'(1);
        #1;
        chk("A_out_valid", out_valid, 1);
        chk("A_out1", out_data, 1);
        @(negedge clk);
        res_data[0] = ADW'(3);
        #1;
        chk("A_out2", out_data, 2);
        @(negedge clk);
        res_data[1] = ADW'(4);
        #1;
        chk("A_out3", out_data, 3);
        @(negedge clk);
        res_valid = 2'b10;
        #1;
        chk("A_out4_valid", out_valid, 1);
        chk("A_out4", out_data, 4);
        @(negedge clk);
        res_valid = '0;
        #1;
        chk("A_busy_end", busy, 0);
        chk("A_err_end", err, 0);

        // lane full stall, resume after one lane 0 result
        do_reset();
        enable = 1; lane_ready = '1; in_valid = 1; out_ready = 0;
        for (int i = 0; i < 8; i++) begin
            in_data = DW'(i + 10);
            #1;
            chk("B_fill_ready", in_ready, 1);
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("B_stall_ready", in_ready, 0);
            chk("B_stall_lane_valid", lane_valid, 0);
            @(negedge clk);
        end
        res_valid = 2'b01; out_ready = 1;
        #1;
        chk("B_collect_valid", out_valid, 1);
        chk("B_collect_ready", in_ready, 0);
        @(negedge clk);
        res_valid = '0;
        #1;
        chk("B_resume_ready", in_ready, 1);
        chk("B_resume_lane_valid", lane_valid, 2'b01);

        // same-lane in and out with cnt = 2
        do_reset();
        enable = 1; lane_ready = '1; in_valid = 1; out_ready = 0;
        repeat (4) @(negedge clk);
        res_valid = 2'b01; out_ready = 1;
        #1;
        chk("C_both_in_ready", in_ready, 1);
        chk("C_both_out_valid", out_valid, 1);
        @(negedge clk);
        in_valid = 0; res_valid = '0;
        #1;
        chk("C_busy", busy, 1);
        res_valid = 2'b11;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (out_valid) got++;
            @(negedge clk);
        end
        chk("C_drain_count", got, 4);
        chk("C_drain_busy", busy, 0);

        // asynchronous reset with 3 beats in flight
        do_reset();
        enable = 1; lane_ready = '1; in_valid = 1;
        repeat (3) @(negedge clk);
        in_valid = 0; res_valid = '1; out_ready = 1;
        #1;
        chk("D_pre_out_valid", out_valid, 1);
        #1;
        rst_n = 0;
        #1;
        chk("D_async_busy", busy, 0);
        chk("D_async_out_valid", out_valid, 0);
        chk("D_async_res_ready", res_ready, 0);
        @(negedge clk);
        res_valid = '0;
        rst_n = 1;

        // sticky error and soft clear
        do_reset();
        res_valid = 2'b10;
        #1;
        chk("E_err_pre", err, 0);
        @(negedge clk);
        res_valid = '0;
        #1;
        chk("E_err_set", err, 1);
        @(negedge clk);
        #1;
        chk("E_err_hold", err, 1);
        enable = 1; lane_ready = '1; in_valid = 1;
        @(negedge clk);
        clear = 1;
        @(negedge clk);
        clear = 0; in_valid = 0;
        #1;
        chk("E_clr_err", err, 0);
        chk("E_clr_busy", busy, 0);
        in_valid = 1;
        #1;
        chk("E_clr_dp", lane_valid, 2'b01);
        @(negedge clk);
        in_valid = 0; res_valid = 2'b01; out_ready = 1;
        #1;
        chk("E_clr_cp", out_valid, 1);
        @(negedge clk);
        res_valid = 2'b10;
        @(negedge clk);
        res_valid = '0;
        #1;
        chk("E_late_result_err", err, 1);

        // randomized run against the queue model
        do_reset();
        nin = 0; nout = 0;
        qexp.delete();
        for (int k = 0; k < N; k++) lq[k].delete();
        repeat (3000) begin
            @(negedge clk);
            enable = ($urandom_range(9) != 0);
            in_valid = $urandom_range(1);
            lane_ready = N'($urandom);
            out_ready = ($urandom_range(3) != 0);
            for (int w = 0; w < DW / 32; w++) in_data[w*32 +: 32] = $urandom;
            in_strb = {4'($urandom), 32'($urandom)};
            for (int k = 0; k < N; k++) begin
                res_strb[k] = VW'($urandom);
                if (lq[k].size() > 0) begin
                    res_valid[k] = $urandom_range(1);
                    res_data[k] = lq[k][0];
                end else begin
                    res_valid[k] = 0;
                    res_data[k] = '0;
                end
            end
            #1;
            dpl = nin % N;
            cpl = nout % N;
            exp_ir = lane_ready[dpl] && enable && (mcnt(dpl) < MO);
            exp_lv = '0;
            if (in_valid && enable && mcnt(dpl) < MO) exp_lv[dpl] = 1'b1;
            exp_ov = res_valid[cpl] && (mcnt(cpl) != 0);
            exp_rr = '0;
            if (out_ready && mcnt(cpl) != 0) exp_rr[cpl] = 1'b1;
            exp_ls = '0;
            for (int i = 0; i < VW; i++) begin
                exp_ls[i] = 1'b1;
                for (int b = 0; b < E; b++) begin
                    if (!in_strb[i*E + b]) exp_ls[i] = 1'b0;
                end
            end
            exp_os = '0;
            for (int i = 0; i < VW; i++) begin
                for (int b = 0; b < E; b++) exp_os[i*E + b] = res_strb[cpl][i];
            end
            chk("R_in_ready", in_ready, exp_ir);
            chk("R_lane_valid", lane_valid, exp_lv);
            chk("R_lane_data", lane_data, in_data[ADW-1:0]);
            chk("R_lane_strb", lane_strb, exp_ls);
            chk("R_out_valid", out_valid, exp_ov);
            chk("R_res_ready", res_ready, exp_rr);
            chk("R_out_strb", out_strb, exp_os);
            chk("R_busy", busy, nin != nout);
            if (exp_ov) begin
                chk("R_out_data", out_data, {32'h0, qexp[0]});
            end
            if (in_valid && exp_ir) begin
                qexp.push_back(in_data[ADW-1:0]);
                lq[dpl].push_back(in_data[ADW-1:0]);
                nin++;
            end
            if (exp_ov && out_ready) begin
                void'(qexp.pop_front());
                void'(lq[cpl].pop_front());
                nout++;
            end
        end
        #1;
        chk("R_err_end", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/sfm_lane_dispatcher.md
SFM_LANE_DISPATCHER -- requirements
Module: sfm_lane_dispatcher

Interface
REQ-001 Parameter DATA_WIDTH, default 288: total stream width in bits; the top 32 bits are reserved.
REQ-002 Parameter ELEM_WIDTH, default 16: floating-point element width in bits; SHALL be a multiple of 8.
REQ-003 Parameter N_LANES, default 2: number of parallel datapath lanes; SHALL be at least 1.
REQ-004 Parameter MAX_OUT, default 4: maximum beats in flight per lane; SHALL be at least 1.
REQ-005 Derived values SHALL be ADW = DATA_WIDTH-32 and VW = ADW/ELEM_WIDTH.
REQ-006 clk_i  in  1  clock; single clock domain.
REQ-007 rst_ni  in  1  reset, asynchronous, active-low.
REQ-008 clear_i  in  1  synchronous soft clear.
REQ-009 enable_i  in  1  dispatch enable.
REQ-010 in_valid_i / in_ready_o  in/out  1/1  input stream handshake.
REQ-011 in_data_i  in  DATA_WIDTH  input data; the top 32 bits are ignored.
REQ-012 in_strb_i  in  DATA_WIDTH/8  input byte strobes.
REQ-013 lane_valid_o / lane_ready_i  out/in  N_LANES each  lane input handshake.
REQ-014 lane_data_o  out  ADW  data broadcast to all lanes.
REQ-015 lane_strb_o  out  VW  per-element strobes.
REQ-016 res_valid_i / res_ready_o  in/out  N_LANES each  lane result handshake.
REQ-017 res_data_i  in  N_LANES x ADW  per-lane results.
REQ-018 res_strb_i  in  N_LANES x VW  per-lane result element strobes.
REQ-019 out_valid_o / out_ready_i  out/in  1/1  output stream handshake.
REQ-020 out_data_o  out  DATA_WIDTH  output data.
REQ-021 out_strb_o  out  DATA_WIDTH/8  output byte strobes.
REQ-022 busy_o  out  1  at least one beat is in flight.
REQ-023 err_o  out  1  sticky protocol error flag.

Function
REQ-024 lane_strb_o[i] SHALL be the AND of in_strb_i bytes i*E .. i*E+E-1, where E = ELEM_WIDTH/8.
REQ-025 lane_data_o SHALL equal in_data_i[ADW-1:0], passed combinationally.
REQ-026 The dispatch pointer dp SHALL select one lane; lane_valid_o[dp] = in_valid_i && enable_i && cnt[dp] < MAX_OUT, and all other lane_valid_o bits SHALL be 0.
REQ-027 in_ready_o SHALL equal lane_ready_i[dp] && enable_i && cnt[dp] < MAX_OUT.
REQ-028 On an input handshake, cnt[dp] SHALL increment, and dp SHALL advance by 1, wrapping from N_LANES-1 to 0.
REQ-029 The collect pointer cp SHALL select the lane that supplies the output: out_valid_o = res_valid_i[cp] && cnt[cp] != 0, and res_ready_o[cp] = out_ready_i && cnt[cp] != 0; all other res_ready_o bits SHALL be 0.
REQ-030 On an output handshake, cnt[cp] SHALL decrement, and cp SHALL advance by 1 with wrap.
REQ-031 Output beats SHALL therefore leave in exactly the input order.
REQ-032 When the input and output handshakes hit the same lane in the same cycle, that lane's cnt SHALL remain unchanged.
REQ-033 out_data_o[ADW-1:0] SHALL equal res_data_i[cp], and out_data_o[DATA_WIDTH-1 -: 32] SHALL be 0.
REQ-034 out_strb_o bytes i*E .. i*E+E-1 SHALL each equal res_strb_i[cp][i], and the top 4 strobe bytes SHALL be 0.
REQ-035 The block SHALL add zero cycles of latency; all data paths are combinational, and only dp, cp, cnt and err are registered.
REQ-036 When cnt[dp] == MAX_OUT (lane full), dispatch SHALL stall with in_ready_o = 0; dp SHALL NOT skip to another lane.
REQ-037 When enable_i = 0, no new dispatch SHALL occur; collection SHALL continue.
REQ-038 err_o SHALL set when res_valid_i[k] = 1 for any k with cnt[k] == 0, and SHALL hold until reset or clear.
REQ-039 busy_o SHALL equal the OR over all lanes of (cnt != 0).
REQ-040 cnt SHALL be $clog2(MAX_OUT+1) bits wide; dp and cp SHALL each be max(1, $clog2(N_LANES)) bits wide.
REQ-041 When N_LANES = 1, dp and cp SHALL stay constant at 0.

Reset
REQ-042 On rst_ni low, asynchronously: dp = 0, cp = 0, every cnt = 0, err_o = 0; as a result busy_o = 0, out_valid_o = 0, and all res_ready_o = 0.
REQ-043 clear_i = 1 SHALL apply the same values at the next clock edge and SHALL take priority over simultaneous handshakes.
REQ-044 A reset or clear in the middle of a transfer SHALL discard all in-flight accounting; results that arrive afterwards SHALL set err_o.

Verification
REQ-045 N_LANES=2; send 4 beats with payloads 1..4; lane 1 answers before lane 0 -> output order is 1, 2, 3, 4, and lane 1 is held (res_ready_o[1] = 0) until lane 0 delivers.
REQ-046 MAX_OUT=4; lane 0 never returns a result -> in_ready_o = 0 once cnt[0] = 4; after one lane 0 result, dispatch resumes.
REQ-047 Input and output handshakes on the same lane in the same cycle with cnt = 2 -> cnt stays 2, and busy_o = 1.
REQ-048 in_strb_i = 0x00000_FFF3 with E = 2 -> lane_strb_o = 0b1111_1101_... (element 1 = 0, element 0 = 1); each result strobe bit set -> 2 output bytes set, top 4 bytes = 0.
REQ-049 res_valid_i[1] = 1 while cnt[1] = 0 -> err_o = 1 on the next cycle and stays 1; after clear_i, err_o = 0, dp = cp = 0, busy_o = 0.
REQ-050 Assert rst_ni with 3 beats in flight -> busy_o = 0 and out_valid_o = 0 immediately, without waiting for a clock edge.
